gshare_btb_predictor: RTL
=========================

# gshare_btb_predictor

Parametrised branch prediction unit for the pipelined 16-bit CPU. It replaces the fixed 64-entry BTB and single global 2-bit counter with three parts: a direct-mapped BTB of configurable depth, a pattern history table (PHT) of per-index saturating counters, and a global history register (GHR). The IF stage consumes its prediction combinationally; the EX stage writes branch resolution back to it.

## Interface
Parameters:
- WORD_SIZE, 16, address and target width
- BTB_ENTRIES, 64, BTB depth; power of two, 4..256; IDX_BITS = log2(BTB_ENTRIES)
- PHT_ENTRIES, 256, PHT depth; power of two; PHT_BITS = log2(PHT_ENTRIES)
- GHR_BITS, 8, global history length; must be ≤ PHT_BITS
- CTR_BITS, 2, counter width (2..3)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on its rising edge
- reset_n  in  1  asynchronous active-low reset
- if_pc  in  WORD_SIZE  PC of the instruction being fetched
- pred_taken  out  1  predict taken; redirect fetch to pred_target
- pred_target  out  WORD_SIZE  BTB target for if_pc
- pred_hit  out  1  BTB entry is valid and its tag matches
- upd_valid  in  1  resolution strobe from EX; asserted at most once per branch
- upd_pc  in  WORD_SIZE  PC of the resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  WORD_SIZE  actual taken target
- upd_ghr  in  GHR_BITS  GHR snapshot carried down the pipe with the branch
- pred_ghr  out  GHR_BITS  current GHR; the pipeline carries it alongside the fetched instruction
- upd_mispredict  in  1  EX found a direction or target mismatch
- mispredict_count  out  16  saturating count of upd_mispredict events

## Operation
- BTB index = pc[IDX_BITS-1:0]. Tag = pc[WORD_SIZE-1:IDX_BITS]. Each entry holds valid, tag and target.
- PHT index with the macro: pc[PHT_BITS-1:0] XOR {zero-pad, ghr}. The lookup uses the live GHR; the update uses upd_ghr.
- pred_hit = valid & tag match.
- pred_taken = pred_hit & counter MSB.
- pred_target is the BTB entry's target. It is don't-care when pred_hit = 0.
- When upd_valid = 1:
  - PHT counter increments if upd_taken, otherwise decrements.
  - The counter saturates at all-ones and at zero.
  - If upd_taken, the BTB entry is written {1, tag(upd_pc), upd_target}, overwriting any aliasing entry.
  - If not taken, the BTB entry is left unchanged.
- GHR:
  - Speculative update at lookup is disallowed.
  - When upd_valid = 1: GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}. This repairs the history after a mispredict.
- mispredict_count increments when upd_valid & upd_mispredict, saturating at 16'hFFFF.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update state. There is no bypass.

## Timing
- Lookup is fully combinational from if_pc and state, with zero cycles of latency, matching the IF-stage next-PC mux.
- Update commits at the posedge where upd_valid = 1. It is visible to a lookup in the following cycle.
- While reset_n = 0, asynchronously:
  - all BTB valid bits = 0
  - all counters = weakly-not-taken (01 for 2-bit; 011 for 3-bit)
  - GHR = 0
  - mispredict_count = 0
  - therefore pred_taken = 0, pred_hit = 0, pred_ghr = 0
- Reset asserted mid-update discards that update. The first edge after release behaves as a fresh start.
- upd_valid with X inputs during reset is ignored.

## Configuration
- BPU_GSHARE_EN defined: the PHT is indexed by pc XOR GHR (gshare). The GHR is maintained and pred_ghr is live.
- BPU_GSHARE_EN undefined:
  - the PHT is indexed by pc[PHT_BITS-1:0] only (bimodal)
  - the GHR register is not built
  - pred_ghr is tied to 0 and upd_ghr is ignored

## Structure
- Package bpu_pkg holds:
  - counter encodings (CTR_SNT, CTR_WNT, CTR_WT, CTR_ST for 2-bit)
  - functions ctr_inc/ctr_dec (saturating)
  - function pht_index(pc, ghr)
  - a typedef for the BTB entry struct
- Sub-module bpu_pht: the counter array with one read port, one write port and asynchronous reset. The BTB and GHR live in the top.

## Test plan
- Reset, then lookup if_pc = 16'h0010 -> pred_hit = 0, pred_taken = 0, mispredict_count = 0.
- Three taken updates at upd_pc = 16'h0010, upd_target = 16'h0040, same upd_ghr -> then lookup 16'h0010 gives pred_hit = 1, pred_target = 16'h0040, pred_taken = 1. The counter stops at 11; a fourth update leaves it at 11.
- Two not-taken updates on that entry -> pred_taken = 0 and pred_hit stays 1. Ten further not-taken updates keep the counter at 00.
- Aliasing: a taken update at upd_pc = 16'h0050 (BTB_ENTRIES = 64, same index as 16'h0010) -> lookup 16'h0010 gives pred_hit = 0; lookup 16'h0050 gives pred_hit = 1.
- With BPU_GSHARE_EN, GHR_BITS = 8: updates with upd_taken = 1,0,1,1 from upd_ghr = 0 chained -> pred_ghr = 8'h0B. The same PC under ghr = 8'h00 and ghr = 8'h0B trains independent counters. Without the macro, pred_ghr stays 0.
- 65 537 consecutive upd_mispredict strobes -> mispredict_count = 16'hFFFF. Asserting reset_n = 0 mid-stream clears it within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/bpu_pkg.sv
// bpu_pkg: counter encodings, saturating counter helpers, PHT index hash and BTB entry type
package bpu_pkg;
  localparam int unsigned MAX_WORD = 32;
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;
  typedef struct packed {
    logic valid;
    logic [MAX_WORD-1:0] tag;
    logic [MAX_WORD-1:0] target;
  } btb_entry_t;
  function automatic logic [2:0] ctr_max(input int unsigned bits);
    return 3'((1 << bits) - 1);
  endfunction
  function automatic logic [2:0] ctr_wnt(input int unsigned bits);
    return 3'((1 << (bits - 1)) - 1);
  endfunction
  function automatic logic [2:0] ctr_inc(input logic [2:0] c, input int unsigned bits);
    return (c == ctr_max(bits)) ? c : c + 3'd1;
  endfunction
  function automatic logic [2:0] ctr_dec(input logic [2:0] c);
    return (c == 3'd0) ? c : c - 3'd1;
  endfunction
  // ghr arrives zero-padded, so only the low PHT bits of pc are mixed with history
  function automatic logic [31:0] pht_index(input logic [31:0] pc, input logic [31:0] ghr);
    return pc ^ ghr;
  endfunction
endpackage

// File: rtl/bpu_pht.sv
// bpu_pht: array of saturating direction counters, one combinational read port and one update port
module bpu_pht import bpu_pkg::*; #(
  parameter int ENTRIES = 256,
  parameter int IDX_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);
  logic [CTR_BITS-1:0] ctr [ENTRIES];
  logic [2:0] cur;
  logic [CTR_BITS-1:0] nxt;
  assign rd_ctr = ctr[rd_idx];
  assign cur = 3'(ctr[wr_idx]);
  assign nxt = CTR_BITS'(wr_taken ? ctr_inc(cur, CTR_BITS) : ctr_dec(cur));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_BITS'(ctr_wnt(CTR_BITS));
    else if (wr_en)
      ctr[wr_idx] <= nxt;
endmodule

// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: direct-mapped BTB plus PHT direction predictor with global history.
// Define BPU_GSHARE_EN for gshare indexing; otherwise the PHT is bimodal and no GHR is built.
module gshare_btb_predictor import bpu_pkg::*; #(
  parameter int WORD_SIZE = 16,
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] if_pc,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  output logic                 pred_hit,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic [GHR_BITS-1:0]  upd_ghr,
  output logic [GHR_BITS-1:0]  pred_ghr,
  input  logic                 upd_mispredict,
  output logic [15:0]          mispredict_count
);
  localparam int IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int PHT_BITS = $clog2(PHT_ENTRIES);
  localparam int TAG_BITS = WORD_SIZE - IDX_BITS;
  logic [BTB_ENTRIES-1:0] valid;
  logic [TAG_BITS-1:0] tags [BTB_ENTRIES];
  logic [WORD_SIZE-1:0] targets [BTB_ENTRIES];
  logic [IDX_BITS-1:0] if_idx, upd_idx;
  logic [TAG_BITS-1:0] if_tag, upd_tag;
  logic [PHT_BITS-1:0] rd_pidx, wr_pidx;
  logic [CTR_BITS-1:0] rd_ctr;
  btb_entry_t hit_entry;
  logic unused;
  assign {if_tag, if_idx} = if_pc;
  assign {upd_tag, upd_idx} = upd_pc;
  assign hit_entry = '{valid: valid[if_idx], tag: MAX_WORD'(tags[if_idx]), target: MAX_WORD'(targets[if_idx])};
  assign pred_hit = hit_entry.valid && (hit_entry.tag == MAX_WORD'(if_tag));
  assign pred_taken = pred_hit && rd_ctr[CTR_BITS-1];
  assign pred_target = hit_entry.target[WORD_SIZE-1:0];
`ifdef BPU_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;
  // history is only ever rebuilt from the resolved branch's snapshot, never speculatively
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ghr <= '0;
    else if (upd_valid) ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
  assign rd_pidx = PHT_BITS'(pht_index(32'(if_pc), 32'(ghr)));
  assign wr_pidx = PHT_BITS'(pht_index(32'(upd_pc), 32'(upd_ghr)));
  assign pred_ghr = ghr;
  assign unused = ^hit_entry;
`else
  assign rd_pidx = PHT_BITS'(pht_index(32'(if_pc), 32'd0));
  assign wr_pidx = PHT_BITS'(pht_index(32'(upd_pc), 32'd0));
  assign pred_ghr = '0;
  assign unused = ^{hit_entry, upd_ghr};
`endif
  bpu_pht #(.ENTRIES(PHT_ENTRIES), .IDX_BITS(PHT_BITS), .CTR_BITS(CTR_BITS)) pht (
    .clk(clk),
    .reset_n(reset_n),
    .rd_idx(rd_pidx),
    .rd_ctr(rd_ctr),
    .wr_en(upd_valid),
    .wr_idx(wr_pidx),
    .wr_taken(upd_taken)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid <= '0;
      mispredict_count <= '0;
    end else begin
      if (upd_valid && upd_taken) valid[upd_idx] <= 1'b1;
      if (upd_valid && upd_mispredict && mispredict_count != 16'hFFFF) mispredict_count <= mispredict_count + 16'd1;
    end
  // payload needs no reset: a cleared valid bit hides whatever it holds
  always_ff @(posedge clk)
    if (upd_valid && upd_taken) begin
      tags[upd_idx] <= upd_tag;
      targets[upd_idx] <= upd_target;
    end
endmodule
